// File: rtl/otter_intr_pkg.sv
// Shared definitions for the OTTER interrupt controller: register map,
// FSM state encodings and CLAIM register field positions.
package otter_intr_pkg;

    localparam logic [31:0] OFF_ENABLE  = 32'h0;
    localparam logic [31:0] OFF_PENDING = 32'h4;
    localparam logic [31:0] OFF_CLAIM   = 32'h8;
    localparam logic [31:0] OFF_EDGE    = 32'hC;

    localparam int CLAIM_INSVC_BIT = 31;
    localparam int CLAIM_ID_LSB    = 0;
    localparam int CLAIM_ID_W      = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } intr_state_t;

endpackage

// File: rtl/intr_src_sync.sv
// One request line: 2-flop synchroniser plus a registered copy of the
// synchronised level for rising-edge detection.
module intr_src_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;

endmodule

// File: rtl/otter_intr_ctrl.sv
// IOBUS-mapped interrupt controller: latches/masks N_SRC requests, picks the
// lowest-index enabled pending source and drives the MCU INTR line.
module otter_intr_ctrl
    import otter_intr_pkg::*;
#(
    parameter int          N_SRC     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h1100_0200
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_SRC-1:0] i_irq_in,
    input  logic             i_int_ack,
    input  logic [31:0]      i_iobus_addr,
    input  logic [31:0]      i_iobus_out,
    input  logic             i_iobus_wr,
    output logic [31:0]      o_iobus_rd,
    output logic             o_intr
);

    localparam logic [N_SRC-1:0] ONE = N_SRC'(1);

    logic [N_SRC-1:0]      r_enable;
    logic [N_SRC-1:0]      r_pending;
    logic [N_SRC-1:0]      r_edge;
    logic [CLAIM_ID_W-1:0] r_id;
    intr_state_t           r_state;
    logic                  r_intr;
    logic [31:0]           r_rd;

    logic [N_SRC-1:0]      w_level;
    logic [N_SRC-1:0]      w_rise;
    logic [N_SRC-1:0]      w_req;
    logic [N_SRC-1:0]      w_set;
    logic [N_SRC-1:0]      w_clr;
    logic [N_SRC-1:0]      w_id_mask;
    logic [CLAIM_ID_W-1:0] w_top_id;
    logic                  w_any;
    logic                  w_sel_en, w_sel_pend, w_sel_claim, w_sel_edge;
    logic                  w_claim_hit;
    logic                  w_latch;
    logic                  w_ack_clr;
    intr_state_t           w_state_nxt;
    logic [31:0]           w_rd_data;
    logic                  w_unused;

    genvar g;
    generate
        for (g = 0; g < N_SRC; g++) begin : g_src
            intr_src_sync u_sync (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .i_async (i_irq_in[g]),
                .o_level (w_level[g]),
                .o_rise  (w_rise[g])
            );
        end
    endgenerate

    assign w_sel_en    = (i_iobus_addr == BASE_ADDR + OFF_ENABLE);
    assign w_sel_pend  = (i_iobus_addr == BASE_ADDR + OFF_PENDING);
    assign w_sel_claim = (i_iobus_addr == BASE_ADDR + OFF_CLAIM);
    assign w_sel_edge  = (i_iobus_addr == BASE_ADDR + OFF_EDGE);
    assign w_claim_hit = i_iobus_wr && w_sel_claim &&
                         (i_iobus_out[CLAIM_ID_LSB +: CLAIM_ID_W] == r_id);
    assign w_id_mask   = ONE << r_id;
    assign w_unused    = &{1'b0, i_iobus_out};

    // Descending scan so the lowest index is the last (winning) assignment.
    always_comb begin
        w_req    = r_pending & r_enable;
        w_any    = |w_req;
        w_top_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_req[i]) w_top_id = CLAIM_ID_W'(i);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_ack_clr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_ASSERT;
                    w_latch     = 1'b1;
                end
            end
            ST_ASSERT: begin
                if (i_int_ack) begin
                    w_state_nxt = ST_SERVICE;
                    w_ack_clr   = 1'b1;
                end else if (!(|(r_enable & w_id_mask))) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (w_claim_hit) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Set is OR'ed in after the clear so a same-cycle set always wins.
    always_comb begin
        w_set = (w_rise & r_edge) | (w_level & ~r_edge);
        w_clr = '0;
        if (i_iobus_wr && w_sel_pend) w_clr = w_clr | i_iobus_out[N_SRC-1:0];
        if (w_ack_clr)                w_clr = w_clr | (w_id_mask & r_edge);
    end

    always_comb begin
        w_rd_data = '0;
        if (w_sel_en)   w_rd_data[N_SRC-1:0] = r_enable;
        if (w_sel_pend) w_rd_data[N_SRC-1:0] = r_pending;
        if (w_sel_edge) w_rd_data[N_SRC-1:0] = r_edge;
        if (w_sel_claim) begin
            w_rd_data[CLAIM_INSVC_BIT]                = (r_state == ST_SERVICE);
            w_rd_data[CLAIM_ID_LSB +: CLAIM_ID_W]     = r_id;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_enable  <= '0;
            r_pending <= '0;
            r_edge    <= '0;
            r_id      <= '0;
            r_state   <= ST_IDLE;
            r_intr    <= 1'b0;
            r_rd      <= '0;
        end else begin
            if (i_iobus_wr && w_sel_en)   r_enable <= i_iobus_out[N_SRC-1:0];
            if (i_iobus_wr && w_sel_edge) r_edge   <= i_iobus_out[N_SRC-1:0];
            r_pending <= (r_pending & ~w_clr) | w_set;
            if (w_latch) r_id <= w_top_id;
            r_state <= w_state_nxt;
            r_intr  <= (w_state_nxt == ST_ASSERT);
            r_rd    <= w_rd_data;
        end
    end

    assign o_intr     = r_intr;
    assign o_iobus_rd = r_rd;

endmodule
